// File: rtl/rdi_pkg.sv
// Shared RDI definitions: link status encodings and the clock-request FSM state encoding.
package rdi_pkg;

  localparam logic [3:0] RDI_STS_RESET     = 4'b0000;
  localparam logic [3:0] RDI_STS_L1        = 4'b0100;
  localparam logic [3:0] RDI_STS_L2        = 4'b1000;
  localparam logic [3:0] RDI_STS_LINKRESET = 4'b1001;
  localparam logic [3:0] RDI_STS_DISABLED  = 4'b1100;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_ACTIVE  = 2'd2,
    ST_RELEASE = 2'd3
  } clk_req_state_e;

  function automatic logic is_known_sts(input logic [3:0] sts);
    return (sts == RDI_STS_RESET) || (sts == RDI_STS_L1) || (sts == RDI_STS_L2) ||
           (sts == RDI_STS_LINKRESET) || (sts == RDI_STS_DISABLED);
  endfunction

endpackage

// File: rtl/clk_req_handshake_if.sv
// PHY-to-adapter clock-request handshake plus the event sources that trigger a request.
interface clk_req_handshake_if;
  logic [3:0] i_pl_state_sts;
  logic       i_pl_inband_pres;
  logic       i_sb_msg_valid;
  logic       i_pl_error_evt;
  logic       i_lp_clk_ack;
  logic       o_pl_clk_req;
  logic       o_evt_ready;
  logic       o_timeout;
  logic       o_proto_err;

  // master: the PHY-side requester; slave: the adapter and event sources driving it
  modport master (
    input  i_pl_state_sts, i_pl_inband_pres, i_sb_msg_valid, i_pl_error_evt, i_lp_clk_ack,
    output o_pl_clk_req, o_evt_ready, o_timeout, o_proto_err
  );

  modport slave (
    output i_pl_state_sts, i_pl_inband_pres, i_sb_msg_valid, i_pl_error_evt, i_lp_clk_ack,
    input  o_pl_clk_req, o_evt_ready, o_timeout, o_proto_err
  );
endinterface

// File: rtl/rdi_evt_detect.sv
// Flags any cycle where status or inband presence changed, or a message/error is pending.
module rdi_evt_detect (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [3:0] i_pl_state_sts,
  input  logic       i_pl_inband_pres,
  input  logic       i_sb_msg_valid,
  input  logic       i_pl_error_evt,
  output logic       o_evt
);
  import rdi_pkg::*;

  logic [3:0] prev_sts_q, prev_sts_d;
  logic       prev_inband_q, prev_inband_d;

  always_comb begin
    prev_sts_d    = i_pl_state_sts;
    prev_inband_d = i_pl_inband_pres;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      prev_sts_q    <= RDI_STS_RESET;
      prev_inband_q <= 1'b0;
    end else begin
      prev_sts_q    <= prev_sts_d;
      prev_inband_q <= prev_inband_d;
    end
  end

  assign o_evt = (i_pl_state_sts != prev_sts_q) | (i_pl_inband_pres != prev_inband_q) |
                 i_sb_msg_valid | i_pl_error_evt;

endmodule

// File: rtl/clk_req_handshake.sv
// PHY-initiated four-phase clock request towards the adapter: raise on any event,
// hold for an idle window once acknowledged, then release and wait for ack to drop.
module clk_req_handshake #(
  parameter int HOLD_CYCLES    = 16,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 11
) (
  input logic i_clk,
  input logic i_rst,
  clk_req_handshake_if.master bus
);
  import rdi_pkg::*;

  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_SAT  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  clk_req_state_e   cs_q, cs_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
  logic             pending_q, pending_d;
  logic             timeout_q, timeout_d;
  logic             proto_err_q, proto_err_d;
  logic             evt;
  logic             ack;

  rdi_evt_detect u_evt_detect (
    .i_clk            (i_clk),
    .i_rst            (i_rst),
    .i_pl_state_sts   (bus.i_pl_state_sts),
    .i_pl_inband_pres (bus.i_pl_inband_pres),
    .i_sb_msg_valid   (bus.i_sb_msg_valid),
    .i_pl_error_evt   (bus.i_pl_error_evt),
    .o_evt            (evt)
  );

  assign ack = bus.i_lp_clk_ack;

  always_comb begin
    cs_d        = cs_q;
    hold_cnt_d  = hold_cnt_q;
    to_cnt_d    = to_cnt_q;
    pending_d   = pending_q;
    timeout_d   = 1'b0;
    proto_err_d = 1'b0;
    case (cs_q)
      ST_IDLE: begin
        if (evt || pending_q) begin
          if (!ack) begin
            cs_d      = ST_REQ;
            pending_d = 1'b0;
            to_cnt_d  = '0;
          end else begin
            pending_d = 1'b1;
          end
        end
      end
      ST_REQ: begin
        if (ack) begin
          cs_d       = ST_ACTIVE;
          hold_cnt_d = HOLD_LD;
          to_cnt_d   = '0;
        end else begin
          // Counter parks one past the terminal value so the pulse cannot repeat.
          if (to_cnt_q == TO_LAST) timeout_d = 1'b1;
          if (to_cnt_q != TO_SAT) to_cnt_d = to_cnt_q + ONE;
        end
      end
      ST_ACTIVE: begin
        if (!ack) begin
          proto_err_d = 1'b1;
          cs_d        = ST_REQ;
          to_cnt_d    = '0;
        end else if (evt) begin
          hold_cnt_d = HOLD_LD;
        end else if (hold_cnt_q <= ONE) begin
          hold_cnt_d = '0;
          cs_d       = ST_RELEASE;
        end else begin
          hold_cnt_d = hold_cnt_q - ONE;
        end
      end
      ST_RELEASE: begin
        if (!ack) begin
          if (pending_q || evt) begin
            cs_d      = ST_REQ;
            pending_d = 1'b0;
            to_cnt_d  = '0;
          end else begin
            cs_d = ST_IDLE;
          end
        end else if (evt) begin
          pending_d = 1'b1;
        end
      end
      default: cs_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cs_q        <= ST_IDLE;
      hold_cnt_q  <= '0;
      to_cnt_q    <= '0;
      pending_q   <= 1'b0;
      timeout_q   <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      cs_q        <= cs_d;
      hold_cnt_q  <= hold_cnt_d;
      to_cnt_q    <= to_cnt_d;
      pending_q   <= pending_d;
      timeout_q   <= timeout_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign bus.o_pl_clk_req = (cs_q == ST_REQ) || (cs_q == ST_ACTIVE);
  assign bus.o_evt_ready  = (cs_q == ST_ACTIVE);
  assign bus.o_timeout    = timeout_q;
  assign bus.o_proto_err  = proto_err_q;

endmodule

// File: tb/tb_clk_req_handshake.sv
// Directed bench for the PHY clock-request handshake; expected values are hand-derived.
module tb_clk_req_handshake;
  import rdi_pkg::*;

  logic i_clk;
  logic i_rst;
  int   n_chk;
  int   n_pass;

  clk_req_handshake_if bus ();

  clk_req_handshake #(
    .HOLD_CYCLES    (16),
    .TIMEOUT_CYCLES (1024),
    .CNT_W          (11)
  ) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(posedge i_clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic req, input logic rdy);
    chk({tag, "_req"}, 32'(bus.o_pl_clk_req), 32'(req));
    chk({tag, "_rdy"}, 32'(bus.o_evt_ready), 32'(rdy));
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    i_rst  = 1'b1;
    bus.i_pl_state_sts   = RDI_STS_RESET;
    bus.i_pl_inband_pres = 1'b0;
    bus.i_sb_msg_valid   = 1'b0;
    bus.i_pl_error_evt   = 1'b0;
    bus.i_lp_clk_ack     = 1'b0;
    tick(2);
    chk_out("rst", 1'b0, 1'b0);
    chk("rst_timeout", 32'(bus.o_timeout), 0);
    chk("rst_proto", 32'(bus.o_proto_err), 0);
    i_rst = 1'b0;

    // 1: sideband message, ack three cycles later, hold window, release, back to idle
    tick(9);
    chk_out("t1_idle", 1'b0, 1'b0);
    bus.i_sb_msg_valid = 1'b1;
    tick(1);
    bus.i_sb_msg_valid = 1'b0;
    chk_out("t1_req", 1'b1, 1'b0);
    tick(2);
    chk_out("t1_wait", 1'b1, 1'b0);
    bus.i_lp_clk_ack = 1'b1;
    tick(1);
    chk_out("t1_active", 1'b1, 1'b1);
    tick(15);
    chk_out("t1_hold15", 1'b1, 1'b1);
    tick(1);
    chk_out("t1_release", 1'b0, 1'b0);
    tick(1);
    chk_out("t1_rel_hold", 1'b0, 1'b0);
    bus.i_lp_clk_ack = 1'b0;
    tick(1);
    chk_out("t1_idle_end", 1'b0, 1'b0);
    tick(3);
    chk_out("t1_stay_idle", 1'b0, 1'b0);

    // 2: status change with no ack, timeout after 1024 cycles, req stays high
    bus.i_pl_state_sts = RDI_STS_L1;
    tick(1);
    chk_out("t2_req", 1'b1, 1'b0);
    tick(1023);
    chk("t2_to_early", 32'(bus.o_timeout), 0);
    tick(1);
    chk("t2_to_pulse", 32'(bus.o_timeout), 1);
    chk_out("t2_to_req", 1'b1, 1'b0);
    tick(1);
    chk("t2_to_once", 32'(bus.o_timeout), 0);
    tick(400);
    chk("t2_to_sat", 32'(bus.o_timeout), 0);
    chk_out("t2_still_req", 1'b1, 1'b0);
    bus.i_lp_clk_ack = 1'b1;
    tick(1);
    chk_out("t2_active", 1'b1, 1'b1);

    // 3: error event with hold counter at 5 reloads the window to 16
    tick(11);
    bus.i_pl_error_evt = 1'b1;
    tick(1);
    bus.i_pl_error_evt = 1'b0;
    chk_out("t3_reload", 1'b1, 1'b1);
    tick(15);
    chk_out("t3_hold15", 1'b1, 1'b1);
    tick(1);
    chk_out("t3_release", 1'b0, 1'b0);

    // 4: inband toggle in RELEASE while ack high is held pending until ack drops
    bus.i_pl_inband_pres = 1'b1;
    tick(1);
    chk_out("t4_pend", 1'b0, 1'b0);
    tick(1);
    chk_out("t4_pend2", 1'b0, 1'b0);
    bus.i_lp_clk_ack = 1'b0;
    tick(1);
    chk_out("t4_rereq", 1'b1, 1'b0);

    // 5: ack drops while ACTIVE
    bus.i_lp_clk_ack = 1'b1;
    tick(1);
    chk_out("t5_active", 1'b1, 1'b1);
    tick(3);
    bus.i_lp_clk_ack = 1'b0;
    tick(1);
    chk("t5_perr", 32'(bus.o_proto_err), 1);
    chk_out("t5_req", 1'b1, 1'b0);
    tick(1);
    chk("t5_perr_once", 32'(bus.o_proto_err), 0);
    chk_out("t5_req_hold", 1'b1, 1'b0);
    bus.i_lp_clk_ack = 1'b1;
    tick(1);
    chk_out("t5_reactive", 1'b1, 1'b1);

    // 6: asynchronous reset mid-ACTIVE, then held L1 status re-requests on the first edge
    tick(3);
    #2;
    i_rst = 1'b1;
    bus.i_lp_clk_ack = 1'b0;
    #1;
    chk_out("t6_async", 1'b0, 1'b0);
    tick(2);
    #2;
    i_rst = 1'b0;
    #1;
    chk_out("t6_pre_edge", 1'b0, 1'b0);
    tick(1);
    chk_out("t6_req", 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
